// File: rtl/gate_pkg.sv
// ---------------------------------------------------------------------------
// gate_pkg : gate select encoding and the per-bit gate primitive
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_XNOR = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_NOT  = 3'd6,
      OP_PASS = 3'd7
   } gate_op_e;

   // Single-bit gate; a lane of any width is built by replicating this per bit.
   function automatic logic gate_apply(gate_op_e op, logic a, logic b);
      logic y;
      y = a;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_NOT:  y = ~a;
         OP_PASS: y = a;
         default: y = a;
      endcase
      return y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gate_popcount.sv
// ---------------------------------------------------------------------------
// gate_popcount : combinational count of set bits in a WIDTH-bit word
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_popcount #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           bits,
   output logic [$clog2(WIDTH+1)-1:0] ones
);

   localparam int ONES_W = $clog2(WIDTH + 1);

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + ONES_W'(bits[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/gate_op_pipe.sv
// ---------------------------------------------------------------------------
// gate_op_pipe : 2-stage valid/ready bitwise gate lane with popcount,
//                operand-equality flag and saturating match counter
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_op_pipe
   import gate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [OP_W-1:0]            in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_y,
   output logic [$clog2(WIDTH+1)-1:0] out_ones,
   output logic                       out_eq,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int              ONES_W  = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              s1_valid;
   logic [WIDTH-1:0]  s1_a;
   logic [WIDTH-1:0]  s1_b;
   gate_op_e          s1_op;

   logic              s1_adv;
   logic              s2_adv;
   logic [WIDTH-1:0]  y_next;
   logic [ONES_W-1:0] ones_next;
   logic              eq_next;

   // A stage may load when it is empty or its contents move on this edge.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_AND;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_op <= gate_op_e'(in_op);
         end
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
         assign y_next[i] = gate_apply(s1_op, s1_a[i], s1_b[i]);
      end
   endgenerate

   assign eq_next = &(s1_a ~^ s1_b);

   gate_popcount #(
      .WIDTH (WIDTH)
   ) u_popcount (
      .bits (y_next),
      .ones (ones_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_ones  <= '0;
         out_eq    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_y    <= y_next;
            out_ones <= ones_next;
            out_eq   <= eq_next;
         end
      end
   end

   // Counts delivered matching beats only; a clear in the same cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (out_valid && out_ready && out_eq && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate_op_pipe.sv
// ---------------------------------------------------------------------------
// tb_gate_op_pipe : scoreboard bench for gate_op_pipe (main + small-counter DUT)
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_op_pipe;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready, out_eq, cnt_clr;
   logic [7:0] in_a, in_b, out_y;
   logic [2:0] in_op;
   logic [3:0] out_ones;
   logic [15:0] match_cnt;

   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_eq, c_cnt_clr;
   logic [7:0] c_in_a, c_in_b, c_out_y;
   logic [2:0] c_in_op;
   logic [3:0] c_out_ones;
   logic [1:0] c_match_cnt;

   typedef struct {
      logic [7:0] y;
      logic [3:0] ones;
      logic       eq;
      longint     t_acc;
      bit         chk_lat;
      bit         seen;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   stalls   = 0;
   int   model_cnt = 0;
   bit   rnd_done;

   always #5 clk = ~clk;

   gate_op_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_ones(out_ones), .out_eq(out_eq),
      .cnt_clr(cnt_clr), .match_cnt(match_cnt)
   );

   gate_op_pipe #(.WIDTH(8), .CNT_W(2)) dut_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_a(c_in_a), .in_b(c_in_b), .in_op(c_in_op),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_y(c_out_y), .out_ones(c_out_ones), .out_eq(c_out_eq),
      .cnt_clr(c_cnt_clr), .match_cnt(c_match_cnt)
   );

   function automatic logic [7:0] model_y(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a ^ b);
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Offer one beat starting at posedge+1; enqueue its expectation on the accepting edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input bit lat);
      bit acc   = 0;
      int guard = 0;
      exp_t e;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = in_ready;
         if (!acc) stalls++;
         @(posedge clk);
         if (acc) begin
            e.y       = model_y(op, a, b);
            e.ones    = 4'($countones(e.y));
            e.eq      = (a == b);
            e.t_acc   = longint'($time);
            e.chk_lat = lat;
            e.seen    = 1'b0;
            q.push_back(e);
         end
         guard++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: checks handshake, data and counter against the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("stale_out_valid", 32'(out_valid), 32'd0);
            end else begin
               chk("out_y", 32'(out_y), 32'(q[0].y));
               chk("out_ones", 32'(out_ones), 32'(q[0].ones));
               chk("out_eq", 32'(out_eq), 32'(q[0].eq));
               chk("match_cnt", 32'(match_cnt), 32'(model_cnt));
               if (!q[0].seen && q[0].chk_lat)
                  chk("latency", 32'(longint'($time) - q[0].t_acc), 32'd15);
               q[0].seen = 1'b1;
               if (out_ready) begin
                  if (q[0].eq && model_cnt < 65535) model_cnt++;
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1; cnt_clr = 0;
      c_in_valid = 0; c_in_a = 0; c_in_b = 0; c_in_op = 0; c_out_ready = 1; c_cnt_clr = 0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_y", 32'(out_y), 32'd0);
      chk("rst_out_ones", 32'(out_ones), 32'd0);
      chk("rst_out_eq", 32'(out_eq), 32'd0);
      chk("rst_match_cnt", 32'(match_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Op sweep on the fixed operand pair, back to back.
      for (int op = 0; op < 8; op++) send(8'hC3, 8'hA5, 3'(op), 1'b1);
      drain();

      // Equality flag and counter.
      send(8'h5A, 8'h5A, 3'd3, 1'b0);
      send(8'h5A, 8'h5B, 3'd3, 1'b0);
      drain();
      chk("eq_match_cnt", 32'(match_cnt), 32'd1);

      // Backpressure: consumer stalls 4 cycles after the first beat.
      send(8'h11, 8'h11, 3'd0, 1'b0);
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Throughput: 16 back-to-back beats, no stalls allowed.
      stalls = 0;
      for (int i = 0; i < 16; i++)
         send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      chk("throughput_stalls", 32'(stalls), 32'd0);
      drain();

      // Random traffic with random consumer backpressure and gaps.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [7:0] ra;
               ra = 8'($urandom);
               send(ra, ($urandom_range(0, 2) == 0) ? ra : 8'($urandom),
                    3'($urandom_range(0, 7)), 1'b0);
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(8'hF0, 8'hF0, 3'd1, 1'b0);
      send(8'h0F, 8'h0F, 3'd1, 1'b0);
      rst = 1'b1;
      q.delete();
      model_cnt = 0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_match_cnt", 32'(match_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Saturating counter on the 2-bit instance.
      for (int i = 0; i < 5; i++) begin
         c_in_a = 8'h3C; c_in_b = 8'h3C; c_in_op = 3'd3; c_in_valid = 1'b1;
         @(negedge clk);
         chk("cnt_in_ready", 32'(c_in_ready), 32'd1);
         @(posedge clk);
         #1 c_in_valid = 1'b0;
         repeat (3) @(posedge clk);
         #1 chk("cnt_sat", 32'(c_match_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      begin
         int guard = 0;
         c_in_valid = 1'b1;
         @(posedge clk);
         #1 c_in_valid = 1'b0;
         @(negedge clk);
         while (!c_out_valid && guard < 20) begin @(negedge clk); guard++; end
         chk("clr_out_valid", 32'(c_out_valid), 32'd1);
         chk("clr_out_y", 32'(c_out_y), 32'hFF);
         chk("clr_out_ones", 32'(c_out_ones), 32'd8);
         chk("clr_out_eq", 32'(c_out_eq), 32'd1);
         c_cnt_clr = 1'b1;
         @(posedge clk);
         #1 c_cnt_clr = 1'b0;
         chk("clr_wins", 32'(c_match_cnt), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gate_op_pipe.md
# gate_op_pipe

Parametrised, pipelined bitwise logic unit generalising the team's single-bit gate primitives: one WIDTH-bit lane applies a runtime-selected two-input gate (AND/OR/XOR/XNOR/NAND/NOR/NOT/PASS) to operands a and b. It sits between a valid/ready producer and consumer, adds a 2-stage registered pipeline with backpressure, and reports result popcount, an operand-equality flag and a saturating equality-match counter. Used as the shared gate datapath for self-checking benches and small control datapaths.

## Interface
- WIDTH, 8: operand/result width in bits (>= 1)
- CNT_W, 16: width of match counter (>= 1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit can accept beat this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_op  input  3  gate select (gate_op_e encoding)
- out_valid  output  1  result beat held
- out_ready  input  1  consumer accepts result
- out_y  output  WIDTH  gate result
- out_ones  output  $clog2(WIDTH+1)  popcount of out_y
- out_eq  output  1  1 when in_a == in_b for this beat
- cnt_clr  input  1  synchronous clear of match_cnt
- match_cnt  output  CNT_W  saturating count of delivered beats with out_eq = 1

## Operation
- gate_op_e: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT (~a, b ignored), 7 PASS (a).
- Stage 1 (S1): on accept (in_valid && in_ready) register a, b, op; s1_valid set.
- Stage 2 (S2): on S1 advance, compute y per op, eq = (a == b) (reduction AND of a XNOR b), popcount(y); register into out_y/out_eq/out_ones; out_valid set.
- Advance rules: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
- Stage valid updates: s1_valid <= in_valid when s1_adv; out_valid <= s1_valid when s2_adv. Registers hold when not advancing.
- Output data stable while out_valid && !out_ready.
- match_cnt: increments by 1 on out_valid && out_ready && out_eq; saturates at 2^CNT_W-1; cnt_clr has priority over increment (clear wins same cycle).
- Popcount and eq independent of op.

## Timing
- Reset: out_valid 0, s1_valid 0, out_y 0, out_ones 0, out_eq 0, match_cnt 0; in_ready 1 while rst high and after release.
- Latency: beat accepted at edge N appears on out_valid after edge N+1 (2 registers, visible cycle after next). Throughput 1 beat/cycle with out_ready held high.
- Backpressure: with out_ready low and both stages full, in_ready drops 0 same cycle; no beat lost or duplicated; order preserved.
- Simultaneous: out_ready rising while both full frees both stages in one cycle (in_ready 1 that cycle).
- Reset mid-operation: asynchronous clear of all valids, data and counter; in-flight beats discarded.
- in_op values are all legal; no error state.

## Structure
- gate_pkg: gate_op_e enum, OP_W = 3 constant, function gate_apply(op, a, b).
- Sub-module gate_popcount #(WIDTH) combinational, output $clog2(WIDTH+1) bits; instantiated once in S2 input path.
- Top contains two pipeline stages and counter; no FSM beyond valid bits.

## Test plan
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid 0, match_cnt 0, in_ready 1 immediately; no stale beat emerges after release.
- Op sweep WIDTH=8, a=8'hC3, b=8'hA5, op 0..7, out_ready 1 -> y = 81, E7, 66, 99, 7E, 18, 3C, C3; ones = 2,6,4,4,6,2,4,4; each 2 cycles after accept.
- Equality: XNOR a=b=8'h5A -> y=FF, ones=8, out_eq 1, match_cnt 1; a=5A,b=5B -> y=FE, out_eq 0, match_cnt unchanged.
- Backpressure: stream 6 beats, out_ready low for 4 cycles after beat 1 -> in_ready 0 once both stages full, out_y held, all 6 beats delivered in order, none dropped.
- Counter: CNT_W=2, 5 equal beats -> match_cnt 1,2,3,3,3; cnt_clr concurrent with a matching delivery -> 0.
- Throughput: 16 back-to-back random beats, out_ready 1 -> 16 results on 16 consecutive cycles matching model.
